// File: rtl/sincos_interp_unit.sv
// rtl/sincos_interp_unit.sv - linear-interpolating sin/cos lookup around a synchronous ROM
// Optional macro SINCOS_INTERP_ROUND_EN: round-half-up instead of floor on the fraction product.
module sincos_interp_unit #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 10,
  parameter int FRAC_W = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IDX_W+FRAC_W-1:0]         sin_phase,
  input  logic [IDX_W+FRAC_W-1:0]         cos_phase,
  output logic [IDX_W-1:0]                rom_sin_addr_a,
  output logic [IDX_W-1:0]                rom_sin_addr_b,
  output logic [IDX_W-1:0]                rom_cos_addr_a,
  output logic [IDX_W-1:0]                rom_cos_addr_b,
  input  logic signed [DATA_W-1:0]        rom_sin_data_a,
  input  logic signed [DATA_W-1:0]        rom_sin_data_b,
  input  logic signed [DATA_W-1:0]        rom_cos_data_a,
  input  logic signed [DATA_W-1:0]        rom_cos_data_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [DATA_W-1:0]        out_sin,
  output logic signed [DATA_W-1:0]        out_cos
);

  localparam int PH_W   = IDX_W + FRAC_W;
  localparam int PROD_W = DATA_W + FRAC_W + 2;

  typedef enum logic [1:0] {IDLE, FETCH, CALC, OUT} state_t;

  state_t            state;
  logic [PH_W-1:0]   sin_ph_q;
  logic [PH_W-1:0]   cos_ph_q;
  logic signed [DATA_W-1:0] calc_sin;
  logic signed [DATA_W-1:0] calc_cos;

`ifdef SINCOS_INTERP_ROUND_EN
  localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) <<< (FRAC_W - 1);
`endif

  // The product never exceeds |delta| * 2^FRAC_W, so the truncated sum stays between a and b.
  function automatic logic signed [DATA_W-1:0] interp(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [FRAC_W-1:0]        frac
  );
    logic signed [DATA_W:0]   delta;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    delta = $signed({b[DATA_W-1], b}) - $signed({a[DATA_W-1], a});
    prod  = $signed({{(FRAC_W+1){delta[DATA_W]}}, delta}) *
            $signed({{(DATA_W+1){1'b0}}, frac});
`ifdef SINCOS_INTERP_ROUND_EN
    prod = prod + ROUND_BIAS;
`endif
    shifted = prod >>> FRAC_W;
    return DATA_W'(shifted + PROD_W'(a));
  endfunction

  assign rom_sin_addr_a = sin_ph_q[PH_W-1:FRAC_W];
  assign rom_sin_addr_b = sin_ph_q[PH_W-1:FRAC_W] + IDX_W'(1);
  assign rom_cos_addr_a = cos_ph_q[PH_W-1:FRAC_W];
  assign rom_cos_addr_b = cos_ph_q[PH_W-1:FRAC_W] + IDX_W'(1);

  always_comb begin
    calc_sin = interp(rom_sin_data_a, rom_sin_data_b, sin_ph_q[FRAC_W-1:0]);
    calc_cos = interp(rom_cos_data_a, rom_cos_data_b, cos_ph_q[FRAC_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sin   <= '0;
      out_cos   <= '0;
      sin_ph_q  <= '0;
      cos_ph_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sin_ph_q <= sin_phase;
            cos_ph_q <= cos_phase;
            in_ready <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: state <= CALC;
        CALC: begin
          out_sin   <= calc_sin;
          out_cos   <= calc_cos;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_interp_unit.sv
// tb/tb_sincos_interp_unit.sv - directed and randomized checks of sincos_interp_unit against an integer model
// Honours SINCOS_INTERP_ROUND_EN the same way as the design build.
module tb_sincos_interp_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sin_phase;
  logic [15:0] cos_phase;
  logic [9:0]  rom_sin_addr_a, rom_sin_addr_b, rom_cos_addr_a, rom_cos_addr_b;
  logic signed [15:0] rom_sin_data_a, rom_sin_data_b, rom_cos_data_a, rom_cos_data_b;
  logic        out_valid;
  logic        out_ready;
  logic signed [15:0] out_sin;
  logic signed [15:0] out_cos;

  int sin_rom [1024];
  int cos_rom [1024];
  int passed = 0;
  int total  = 0;

  sincos_interp_unit #(.DATA_W(16), .IDX_W(10), .FRAC_W(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sin_phase(sin_phase), .cos_phase(cos_phase),
    .rom_sin_addr_a(rom_sin_addr_a), .rom_sin_addr_b(rom_sin_addr_b),
    .rom_cos_addr_a(rom_cos_addr_a), .rom_cos_addr_b(rom_cos_addr_b),
    .rom_sin_data_a(rom_sin_data_a), .rom_sin_data_b(rom_sin_data_b),
    .rom_cos_data_a(rom_cos_data_a), .rom_cos_data_b(rom_cos_data_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sin(out_sin), .out_cos(out_cos)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the address.
  always @(posedge clk) begin
    rom_sin_data_a <= 16'(sin_rom[rom_sin_addr_a]);
    rom_sin_data_b <= 16'(sin_rom[rom_sin_addr_b]);
    rom_cos_data_a <= 16'(cos_rom[rom_cos_addr_a]);
    rom_cos_data_b <= 16'(cos_rom[rom_cos_addr_b]);
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int floor_div64(input int p);
    return (p >= 0) ? p / 64 : -((-p + 63) / 64);
  endfunction

  // Value on the straight line from a to b at frac/64, floored (or rounded half-up).
  function automatic int model(input int a, input int b, input int frac);
    int p;
    p = (b - a) * frac;
`ifdef SINCOS_INTERP_ROUND_EN
    p = p + 32;
`endif
    return a + floor_div64(p);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int sidx, input int sfrac, input int cidx, input int cfrac,
                         input int hold, input string tag,
                         output int got_sin, output int got_cos);
    int es, ec, sb, cb;
    sb = (sidx + 1) % 1024;
    cb = (cidx + 1) % 1024;
    es = model(sin_rom[sidx], sin_rom[sb], sfrac);
    ec = model(cos_rom[cidx], cos_rom[cb], cfrac);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    sin_phase = 16'(sidx * 64 + sfrac);
    cos_phase = 16'(cidx * 64 + cfrac);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_fetch_valid"}, out_valid, 0);
    check({tag, "_sin_addr_a"}, rom_sin_addr_a, sidx);
    check({tag, "_sin_addr_b"}, rom_sin_addr_b, sb);
    check({tag, "_cos_addr_a"}, rom_cos_addr_a, cidx);
    check({tag, "_cos_addr_b"}, rom_cos_addr_b, cb);
    tick();
    check({tag, "_calc_valid"}, out_valid, 0);
    tick();
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_out_in_ready"}, in_ready, 0);
    check({tag, "_out_sin"}, out_sin, es);
    check({tag, "_out_cos"}, out_cos, ec);
    got_sin = out_sin;
    got_cos = out_cos;
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      sin_phase = 16'($urandom);
      cos_phase = 16'($urandom);
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
      check({tag, "_hold_sin"}, out_sin, es);
      check({tag, "_hold_cos"}, out_cos, ec);
      check({tag, "_hold_addr"}, rom_sin_addr_a, sidx);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done_in_ready"}, in_ready, 1);
    check({tag, "_done_valid"}, out_valid, 0);
    check({tag, "_kept_sin"}, out_sin, es);
    check({tag, "_kept_cos"}, out_cos, ec);
  endtask

  initial begin
    int gs, gc;
    int si, sf, ci, cf;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sin_phase = '0;
    cos_phase = '0;
    for (int i = 0; i < 1024; i++) begin
      sin_rom[i] = 0;
      cos_rom[i] = 0;
    end
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sin", out_sin, 0);
    check("rst_out_cos", out_cos, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_addr_a", rom_sin_addr_a, 0);
    check("rst_addr_b", rom_cos_addr_b, 1);
    reset = 1'b0;
    tick();

    sin_rom[5] = 100;   sin_rom[6] = 164;
    cos_rom[7] = 1000;  cos_rom[8] = 936;
    run_txn(5, 32, 7, 16, 0, "basic", gs, gc);
    check("basic_sin_132", gs, 132);
    check("basic_cos_984", gc, 984);

    cos_rom[7] = -200;  cos_rom[8] = -264;
    run_txn(5, 0, 7, 48, 0, "negative", gs, gc);
    check("neg_cos_m248", gc, -248);
    check("frac0_sin_exact", gs, 100);

    sin_rom[1023] = -10; sin_rom[0] = 10;
    cos_rom[1023] = -10; cos_rom[0] = 10;
    run_txn(1023, 32, 1023, 0, 0, "wrap", gs, gc);
    check("wrap_sin_0", gs, 0);
    check("wrap_cos_a", gc, -10);

    sin_rom[20] = 0; sin_rom[21] = 3;
    run_txn(20, 32, 20, 32, 0, "round", gs, gc);
`ifdef SINCOS_INTERP_ROUND_EN
    check("round_sin_2", gs, 2);
`else
    check("round_sin_1", gs, 1);
`endif

    run_txn(5, 32, 7, 48, 5, "hold", gs, gc);

    sin_phase = 16'(5 * 64 + 32);
    cos_phase = 16'(7 * 64 + 16);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rstcalc_valid", out_valid, 0);
    check("rstcalc_sin", out_sin, 0);
    check("rstcalc_cos", out_cos, 0);
    check("rstcalc_in_ready", in_ready, 1);
    check("rstcalc_addr_b", rom_sin_addr_b, 1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rstcalc_no_stale", out_valid, 0);
    end
    check("rstcalc_ready_after", in_ready, 1);

    for (int i = 0; i < 1024; i++) begin
      sin_rom[i] = int'($urandom_range(65535)) - 32768;
      cos_rom[i] = int'($urandom_range(65535)) - 32768;
    end
    for (int t = 0; t < 40; t++) begin
      si = (t % 10 == 3) ? 1023 : int'($urandom_range(1023));
      ci = int'($urandom_range(1023));
      sf = (t % 8 == 0) ? 0 : int'($urandom_range(63));
      cf = int'($urandom_range(63));
      run_txn(si, sf, ci, cf, int'($urandom_range(2)), $sformatf("rand%0d", t), gs, gc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
